// File: rtl/rv32_types.sv
// rtl/rv32_types.sv - shared RV32 integer-core types and constants
//
// Purpose: common types for the decode/writeback datapath.
//   RV32_XLEN / RV32_NREGS : default data width and register count
//   rv32_word              : one XLEN-wide integer word
//   reg_id_t               : architectural register index (x0..x31)
//   rf_state_t             : register-file sweep sequencer state
package rv32_types;

  localparam int RV32_XLEN  = 32;
  localparam int RV32_NREGS = 32;

  typedef logic [RV32_XLEN-1:0]          rv32_word;
  typedef logic [$clog2(RV32_NREGS)-1:0] reg_id_t;

  // RF_IDLE: normal operation; RF_CLEAR: zero sweep in progress.
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rv32_rf_clear_seq.sv
// rtl/rv32_rf_clear_seq.sv - register-file zero-sweep sequencer
//
// Purpose: owns the IDLE/CLEAR state machine and the sweep index. After
// reset, or after clear_req in IDLE, it walks entries 1..DEPTH-1 one per
// clock and asks the top to write zero to each. Entry 0 is never swept
// because it is hardwired to zero at the read side.
//
// Ports:
//   clk        in   clock
//   resetn     in   asynchronous active-low reset (enters CLEAR at entry 1)
//   clear_req  in   start a new sweep; only looked at in IDLE
//   ready      out  1 while IDLE
//   clr_we     out  sweep write strobe (1 throughout CLEAR)
//   clr_addr   out  entry being zeroed this cycle
module rv32_rf_clear_seq
  import rv32_types::*;
#(
  parameter int DEPTH = RV32_NREGS,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear_req,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  rf_state_t       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= FIRST_IDX;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clear_req) begin
          state_d   = RF_CLEAR;
          clr_idx_d = FIRST_IDX;
        end
      end
      RF_CLEAR: begin
        // Leave on the edge that zeroes the last entry; the index is left
        // parked there, so it can never wrap back through 0.
        if (clr_idx_q == LAST_IDX) begin
          state_d = RF_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
    endcase
  end

  assign ready    = (state_q == RF_IDLE);
  assign clr_we   = (state_q == RF_CLEAR);
  assign clr_addr = clr_idx_q;

endmodule

// File: rtl/rv32_register_file_mp.sv
// rtl/rv32_register_file_mp.sv - multi-port integer register file with zero sweep
//
// Purpose: NUM_READ combinational read ports, NUM_WRITE clocked write ports,
// entry 0 hardwired to zero, and a zero-sweep sequencer that runs after
// reset and on clear_req. While sweeping, user writes are dropped and all
// reads return 0, so nothing uninitialised is ever visible.
//
// Optional build macro RV32_RF_BYPASS_EN: when defined, a read port whose
// address matches an enabled write port in the same cycle (IDLE only, not
// x0) returns that port's write data; highest-indexed write port wins.
//
// Ports:
//   clk        in   clock
//   resetn     in   asynchronous active-low reset
//   clear_req  in   request a full zero sweep (IDLE only)
//   ready      out  1 = IDLE: writes accepted, reads valid
//   we         in   [NUM_WRITE]        per-port write enable
//   waddr      in   [NUM_WRITE*AW]     packed write addresses, port i at [i*AW +: AW]
//   wdata      in   [NUM_WRITE*WIDTH]  packed write data
//   raddr      in   [NUM_READ*AW]      packed read addresses
//   rdata      out  [NUM_READ*WIDTH]   packed read data, combinational
module rv32_register_file_mp
  import rv32_types::*;
#(
  parameter int WIDTH     = RV32_XLEN,
  parameter int DEPTH     = RV32_NREGS,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear_req,
  output logic                       ready,
  input  logic [NUM_WRITE-1:0]       we,
  input  logic [NUM_WRITE*AW-1:0]    waddr,
  input  logic [NUM_WRITE*WIDTH-1:0] wdata,
  input  logic [NUM_READ*AW-1:0]     raddr,
  output logic [NUM_READ*WIDTH-1:0]  rdata
);

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  rv32_rf_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .resetn    (resetn),
    .clear_req (clear_req),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // Storage is deliberately not reset; the sweep initialises it and reads
  // are forced to 0 until the sweep has finished.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (ready) begin
      // Ports are visited in ascending order, so on an address collision
      // the last (highest-indexed) assignment is the one that lands.
      for (int i = 0; i < NUM_WRITE; i++) begin
        if (we[i] && (waddr[i*AW +: AW] != '0)) begin
          mem[waddr[i*AW +: AW]] <= wdata[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < NUM_READ; j++) begin
      if (ready && (raddr[j*AW +: AW] != '0)) begin
        rdata[j*WIDTH +: WIDTH] = mem[raddr[j*AW +: AW]];
`ifdef RV32_RF_BYPASS_EN
        for (int i = 0; i < NUM_WRITE; i++) begin
          if (we[i] && (waddr[i*AW +: AW] == raddr[j*AW +: AW])) begin
            rdata[j*WIDTH +: WIDTH] = wdata[i*WIDTH +: WIDTH];
          end
        end
`else
        // Without bypass a same-cycle write shows up only after the edge.
`endif
      end
    end
  end

endmodule

// File: tb/tb_rv32_register_file_mp.sv
// tb/tb_rv32_register_file_mp.sv - self-checking bench for rv32_register_file_mp
module tb_rv32_register_file_mp;
  import rv32_types::*;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              clear_req = 1'b0;
  logic              ready;
  logic [NW-1:0]     we = '0;
  logic [NW*AW-1:0]  waddr = '0;
  logic [NW*W-1:0]   wdata = '0;
  logic [NR*AW-1:0]  raddr = '0;
  logic [NR*W-1:0]   rdata;

  rv32_register_file_mp #(
    .WIDTH     (W),
    .DEPTH     (D),
    .NUM_READ  (NR),
    .NUM_WRITE (NW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clear_req (clear_req),
    .ready     (ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: architectural register contents plus the number of clock
  // edges still needed before the file is usable again.
  rv32_word model [D];
  int       busy;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start_sweep();
    for (int a = 0; a < D; a++) model[a] = '0;
    busy = D - 1;
  endtask

  function automatic rv32_word exp_read(int j);
    reg_id_t  ra;
    rv32_word v;
    ra = raddr[j*AW +: AW];
    if (busy != 0 || ra == 0) return '0;
    v = model[ra];
`ifdef RV32_RF_BYPASS_EN
    for (int i = 0; i < NW; i++)
      if (we[i] && waddr[i*AW +: AW] == ra) v = wdata[i*W +: W];
`endif
    return v;
  endfunction

  task automatic update_model();
    if (!resetn) begin
      start_sweep();
    end else if (busy == 0) begin
      for (int i = 0; i < NW; i++)
        if (we[i] && waddr[i*AW +: AW] != 0) model[waddr[i*AW +: AW]] = wdata[i*W +: W];
      if (clear_req) start_sweep();
    end else begin
      busy--;
    end
  endtask

  task automatic set_w(int i, logic en, int a, logic [31:0] d);
    we[i]            = en;
    waddr[i*AW +: AW] = AW'(a);
    wdata[i*W +: W]   = d;
  endtask

  task automatic set_r(int j, int a);
    raddr[j*AW +: AW] = AW'(a);
  endtask

  // Inputs are set just after a posedge; outputs are checked on the
  // negedge; the model advances on the posedge.
  task automatic cycle(string tag);
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, ready}, (busy == 0) ? 32'd1 : 32'd0);
    for (int j = 0; j < NR; j++)
      check($sformatf("%s_rd%0d", tag, j), rdata[j*W +: W], exp_read(j));
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic wait_ready(string tag);
    int n = 0;
    while (!ready && n < 100) begin
      set_w(0, 1'($urandom_range(0, 1)), $urandom_range(0, D-1), $urandom);
      set_r(0, n % D);
      set_r(1, (n + 1) % D);
      cycle(tag);
      n++;
    end
    check({tag, "_len"}, n, 31);
    we = '0;
  endtask

  initial begin
    logic [31:0] byp_exp;
    start_sweep();
    resetn = 1'b0;
    repeat (3) cycle("rst_low");
    resetn = 1'b1;
    wait_ready("rst");

    for (int a = 1; a < D; a++) begin
      set_r(0, a);
      set_r(1, D - a);
      cycle("rd_all");
    end

    set_w(0, 1, 5, 32'hDEADBEEF);
    set_r(0, 5);
    set_r(1, 0);
    cycle("wr5");
    we = '0;
    #1;
    check("x5", rdata[W-1:0], 32'hDEADBEEF);
    check("x0_r1", rdata[2*W-1:W], 32'h0);

    set_w(0, 1, 7, 32'h11);
    set_w(1, 1, 7, 32'h22);
    set_r(0, 7);
    cycle("conf");
    we = '0;
    #1;
    check("x7", rdata[W-1:0], 32'h22);

    set_w(0, 1, 0, 32'hFFFFFFFF);
    set_w(1, 1, 0, 32'hFFFFFFFF);
    set_r(0, 0);
    cycle("wr0");
    we = '0;
    #1;
    check("x0", rdata[W-1:0], 32'h0);

    set_w(0, 1, 3, 32'h1234);
    cycle("wr3");
    set_w(0, 1, 9, 32'h55);
    clear_req = 1'b1;
    cycle("clr_req");
    clear_req = 1'b0;
    wait_ready("clr");
    set_r(0, 3);
    set_r(1, 9);
    #1;
    check("x3_clr", rdata[W-1:0], 32'h0);
    check("x9_clr", rdata[2*W-1:W], 32'h0);

    clear_req = 1'b1;
    cycle("clr2");
    clear_req = 1'b0;
    repeat (9) cycle("mid");
    resetn = 1'b0;
    start_sweep();
    #1;
    check("mid_rst_ready", {31'b0, ready}, 32'd0);
    cycle("mid_low");
    cycle("mid_low");
    resetn = 1'b1;
    wait_ready("mid");

`ifdef RV32_RF_BYPASS_EN
    byp_exp = 32'hCAFE;
`else
    byp_exp = 32'h0;
`endif
    set_w(0, 1, 4, 32'hCAFE);
    set_w(1, 0, 0, 32'h0);
    set_r(0, 4);
    #1;
    check("bypass", rdata[W-1:0], byp_exp);
    cycle("byp");
    we = '0;
    #1;
    check("x4", rdata[W-1:0], 32'hCAFE);

    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NW; i++)
        set_w(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
      for (int j = 0; j < NR; j++)
        set_r(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, D-1) : $urandom_range(0, 7));
      clear_req = ($urandom_range(0, 59) == 0);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
